// File: rtl/elastic_shift_register_with_valid_ready.sv
// elastic_shift_register_with_valid_ready: valid/ready pipeline whose empty stages collapse under back-pressure
module elastic_shift_register_with_valid_ready #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         up_vld,
  output logic                         up_rdy,
  input  logic [width-1:0]             up_data,
  output logic                         down_vld,
  input  logic                         down_rdy,
  output logic [width-1:0]             down_data,
  output logic [$clog2(depth+1)-1:0]   count
);
  localparam int cw = $clog2(depth+1);
  logic [depth-1:0] vld_q, vld_d, rdy, prev_vld;
  logic [width-1:0] data_q [depth];
  logic [width-1:0] data_d [depth];
  logic [width-1:0] prev_data [depth];
  logic [cw-1:0] count_q, count_d;
  logic acc, out;
  // ready ripples back from the output; a stage moves when it is empty or its successor moves
  always_comb begin
    rdy = '0;
    rdy[depth-1] = !vld_q[depth-1] | down_rdy;
    for (int i = depth-2; i >= 0; i--) rdy[i] = !vld_q[i] | rdy[i+1];
  end
  // stage advance: valids shift where ready, data loads only when a real word arrives
  always_comb begin
    prev_vld = {vld_q[depth-2:0], up_vld};
    prev_data[0] = up_data;
    for (int i = 1; i < depth; i++) prev_data[i] = data_q[i-1];
    for (int i = 0; i < depth; i++) begin
      vld_d[i] = flush ? 1'b0 : rdy[i] ? prev_vld[i] : vld_q[i];
      data_d[i] = (rdy[i] & prev_vld[i]) ? prev_data[i] : data_q[i];
    end
  end
  // occupancy tracks accepts against outputs; flush discards everything including this cycle's transfer
  always_comb begin
    acc = up_vld & up_rdy;
    out = vld_q[depth-1] & down_rdy;
    count_d = flush ? '0 : (acc & !out) ? count_q + cw'(1) : (out & !acc) ? count_q - cw'(1) : count_q;
  end
  // valid and count state
  always_ff @(posedge clk) begin
    vld_q   <= rst ? '0 : vld_d;
    count_q <= rst ? '0 : count_d;
  end
  // data stages carry no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < depth; i++) data_q[i] <= data_d[i];
  end
  assign up_rdy    = rdy[0] & !flush;
  assign down_vld  = vld_q[depth-1];
  assign down_data = data_q[depth-1];
  assign count     = count_q;
endmodule

// File: doc/elastic_shift_register_with_valid_ready.md
# elastic_shift_register_with_valid_ready

Parametrised valid/ready pipeline of `depth` stages carrying `width`-bit words. Generalises the valid-qualified shift register: words advance only when valid, downstream back-pressure stalls the pipe, and empty stages (bubbles) collapse, so a stalled output absorbs up to `depth` words. It sits between arithmetic pipeline producers and consumers that can stall, such as the sqrt/formula pipelines.

## Interface
- `width`, 8, data word width in bits (>= 1)
- `depth`, 8, number of register stages (>= 2)
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  reset, synchronous, active-high
- `flush`  in  1  synchronous clear of all stage valids; priority below `rst`, above traffic
- `up_vld`  in  1  upstream word valid
- `up_rdy`  out  1  pipe can accept a word this cycle
- `up_data`  in  width  upstream word
- `down_vld`  out  1  output word valid
- `down_rdy`  in  1  downstream accepts the output word
- `down_data`  out  width  output word (content of the last stage)
- `count`  out  $clog2(depth+1)  number of valid stages

## Operation
- Stage i (0..depth-1) holds `vld[i]` and `data[i]`. Stage 0 is fed from `up_*`. Stage depth-1 drives `down_vld`/`down_data`.
- Ready chain (combinational):
  - `rdy[depth-1] = !vld[depth-1] | down_rdy`
  - `rdy[i] = !vld[i] | rdy[i+1]`
  - `up_rdy = rdy[0] & !flush`
- Advance: when `rdy[i]` is high, `vld[i] <= vld[i-1]`, using `up_vld` for i=0. When `rdy[i]` is low, stage i holds.
- `data[i]` loads only when `rdy[i] & vld[i-1]` is high (`up_vld` for i=0). The data registers have no reset.
- Bubble collapse: an empty stage is always ready, so a word moves forward even if downstream stages are stalled.
- `count`:
  - Registered. Equals popcount of `vld`.
  - Increments on accept without output, decrements on output without accept, and holds otherwise.
  - Never exceeds `depth`.
- Full, defined as `count == depth`:
  - `up_rdy = down_rdy`.
  - With `down_rdy=1`, the full pipe streams one word per cycle.
- Empty: `down_vld=0` and `up_rdy=1` (unless `flush` is high).
- `flush=1`:
  - All `vld` cleared and `count` set to 0 at the next edge.
  - The `up_*` word in that cycle is not accepted (`up_rdy=0`).
  - `down_*` in the flush cycle still reflects current state, but its transfer is discarded.
- `rst=1` gives the same result as flush. It also overrides everything mid-operation.
- Ordering: words leave in acceptance order with no loss or duplication.
- Output stability: while `down_vld=1` and `down_rdy=0`, `down_vld` and `down_data` stay stable.

## Timing
- Reset values: `vld`=0, `down_vld`=0, `count`=0. `up_rdy`=1 in the first cycle after reset if `flush`=0. `down_data` is don't-care while `down_vld=0`.
- Latency: a word accepted in cycle t (`up_vld & up_rdy`) appears with `down_vld=1` in cycle t+depth, provided no stall. This matches the plain shift register.
- Throughput: 1 word/cycle sustained when `down_rdy=1`.
- A stall adds latency equal to the stall cycles.
- `up_rdy` is combinational from `down_rdy` through `depth` levels; this is accepted for depth <= 16.
- `down_vld` and `down_data` come from registers only.

## Test plan
- **Streaming** (depth=4, width=8): `down_rdy=1`, `up_data` = 1..10 on consecutive cycles starting at cycle t → `down_data` = 1..10 on cycles t+4..t+13, `down_vld` continuous, `count` steady at 4.
- **Sparse input**: `up_vld` on alternate cycles, values 0xA0..0xA4, `down_rdy=1` → identical alternating pattern at output, latency 4, `count` never exceeds 2.
- **Back-pressure fill**: `down_rdy=0`, 6 words offered back-to-back →
  - exactly 4 words accepted, then `up_rdy=0` and `count=4`;
  - raising `down_rdy` outputs words 1..6 in order, nothing lost or duplicated.
- **Bubble collapse**: word 0x11, then 3 idle cycles, then word 0x22; `down_rdy=0` from the cycle 0x11 appears at the output →
  - 0x22 reaches stage 2 and is held there, `count=2`;
  - after `down_rdy=1`, 0x11 and 0x22 leave on consecutive cycles.
- **Full pass-through**: `count=4`, `down_rdy=1`, `up_vld=1` → `up_rdy=1` every cycle, `count` stays 4, one output per cycle.
- **Flush/reset mid-stream**: `count=3`, `flush=1` for one cycle with `up_vld=1` →
  - `up_rdy=0` in that cycle;
  - next cycle `count=0`, `down_vld=0`, and the flush-cycle input never appears at the output;
  - repeat with `rst` and check the same result.
